edc_ecc_writer: RTL
===================

EDC_ECC_WRITER -- requirements
Module: edc_ecc_writer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: memory-ack wait limit in cycles per memory access.
REQ-002 SHALL have port i_clk  in  1  clock; all logic on rising edge.
REQ-003 SHALL have port i_rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_sel  in  1  bus select.
REQ-005 SHALL have port i_we  in  1  bus write enable.
REQ-006 SHALL have port i_byte_en  in  4  bus byte enables, bit n selects data[8n+7:8n].
REQ-007 SHALL have port i_addr  in  32  bus word address.
REQ-008 SHALL have port i_bus_data  in  32  bus write data.
REQ-009 SHALL have port i_mem_rdata  in  32  memory read data, already corrected by the corrector.
REQ-010 SHALL have port i_rd_ue  in  1  corrector reports an uncorrectable error on i_mem_rdata.
REQ-011 SHALL have port i_mem_ack  in  1  AND of data-memory ack and ECC-memory ack.
REQ-012 SHALL have port o_mem_req  out  1  memory access request.
REQ-013 SHALL have port o_mem_we  out  1  memory write (1) or read (0).
REQ-014 SHALL have port o_mem_addr  out  32  memory address.
REQ-015 SHALL have port o_mem_wdata  out  32  data written to data memory.
REQ-016 SHALL have port o_mem_ecc  out  8  SECDED check byte written to ECC memory.
REQ-017 SHALL have port o_ack  out  1  bus ack, one-cycle pulse.
REQ-018 SHALL have port o_err  out  1  bus error, pulses only together with o_ack.
REQ-019 SHALL have port o_busy  out  1  high whenever state is not IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, RMW_READ, WRITE, DONE, ERROR.
REQ-021 IDLE SHALL capture addr, data and byte_en when i_sel&i_we; i_sel with i_we=0 SHALL be ignored.
REQ-022 Capture with byte_en=4'hF SHALL go to WRITE; byte_en=4'h0 SHALL go to DONE with no memory access; any other value SHALL go to RMW_READ.
REQ-023 RMW_READ SHALL drive o_mem_req=1, o_mem_we=0; on i_mem_ack with i_rd_ue=0 it SHALL merge enabled bus bytes over i_mem_rdata into the write buffer and go to WRITE; with i_rd_ue=1 it SHALL go to ERROR.
REQ-024 WRITE SHALL drive o_mem_req=1, o_mem_we=1, o_mem_wdata=buffer, o_mem_ecc=SECDED(buffer); on i_mem_ack it SHALL go to DONE.
REQ-025 Memory outputs SHALL be registered and held stable while o_mem_req=1; o_mem_req SHALL drop on the edge after the cycle in which i_mem_ack is sampled high.
REQ-026 DONE SHALL assert o_ack=1, o_err=0 for one cycle and return to IDLE.
REQ-027 ERROR SHALL assert o_ack=1, o_err=1 for one cycle, perform no memory write, and return to IDLE.
REQ-028 A wait counter SHALL clear on entry to RMW_READ and WRITE; TIMEOUT consecutive cycles without i_mem_ack SHALL go to ERROR.
REQ-029 i_sel while not IDLE (including DONE/ERROR) SHALL be ignored; no new capture until IDLE.
REQ-030 Latency: full write SHALL ack 1 cycle after the mem-ack cycle; byte_en=0 SHALL ack 1 cycle after capture.
REQ-031 ECC SHALL be (39,32) SECDED: data bits placed ascending in non-power-of-two codeword positions 3..38; o_mem_ecc[k], k=0..6, SHALL be the XOR of data bits whose position has bit k set; o_mem_ecc[7] SHALL be the XOR of all 32 data bits and ecc[6:0].

Reset
REQ-032 On i_rst, state SHALL become IDLE and o_mem_req, o_mem_we, o_ack, o_err, o_busy SHALL be 0; o_mem_addr, o_mem_wdata, o_mem_ecc and the counter SHALL be 0.
REQ-033 Reset mid-transfer SHALL abort it without o_ack, dropping o_mem_req on the reset edge.

Structure
REQ-034 Package edc_pkg SHALL hold the state encoding, ECC width (8), data width (32) and TIMEOUT default.
REQ-035 The SECDED generator SHALL be the combinational sub-module edc_secded_enc, shared with the corrector's syndrome logic.

Verification
REQ-036 Full write of addr 0x10, data 0x00000001, byte_en F, ack after 2 cycles -> one mem write, wdata 0x00000001, ecc 0x83, o_ack 1 cycle after ack, o_err=0.
REQ-037 Partial write of data 0x000000AA, byte_en 4'b0001, mem read returns 0x12345678 -> read then write of wdata 0x123456AA, o_ack, o_err=0.
REQ-038 Partial write with i_rd_ue=1 on the read ack -> no write, o_ack=o_err=1 for one cycle.
REQ-039 i_mem_ack never asserted -> o_ack=o_err=1 exactly TIMEOUT+1 cycles after o_mem_req rises, o_mem_req then 0.
REQ-040 i_rst asserted during WRITE -> next cycle o_mem_req=0, o_busy=0, no o_ack; byte_en=0 write -> o_ack with no o_mem_req.

Source files
------------

// File: rtl/edc_pkg.sv
// Shared definitions for the ECC write path: FSM encoding, widths and
// the SECDED codeword position map used by encoder and corrector.
package edc_pkg;

  localparam int DATA_W      = 32;
  localparam int ECC_W       = 8;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RMW_READ = 3'd1,
    ST_WRITE    = 3'd2,
    ST_DONE     = 3'd3,
    ST_ERROR    = 3'd4
  } state_e;

  // Codeword position of data bit idx: the idx-th non-power-of-two value from 3 up.
  function automatic logic [6:0] secded_pos(input int idx);
    int n;
    n = 0;
    secded_pos = 7'd0;
    for (int p = 3; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == idx) begin
          secded_pos = 7'(p);
        end
        n++;
      end
    end
  endfunction

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [3:0]        be);
    merge_bytes = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        merge_bytes[8*b +: 8] = new_w[8*b +: 8];
      end
    end
  endfunction

endpackage

// File: rtl/edc_secded_enc.sv
// Combinational (39,32) SECDED check-byte generator; also feeds the
// corrector's syndrome computation.
module edc_secded_enc
  import edc_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [ECC_W-1:0]  ecc_o
);

  logic [ECC_W-1:0] ecc_s;
  logic [6:0]       pos_s;

  // Hamming bits from codeword positions, then overall parity in bit 7.
  always_comb begin
    ecc_s = '0;
    pos_s = 7'd0;
    for (int i = 0; i < DATA_W; i++) begin
      pos_s = secded_pos(i);
      for (int k = 0; k < 7; k++) begin
        ecc_s[k] = ecc_s[k] ^ (data_i[i] & pos_s[k]);
      end
    end
    ecc_s[7] = ^{data_i, ecc_s[6:0]};
  end

  assign ecc_o = ecc_s;

endmodule

// File: rtl/edc_ecc_writer.sv
// Bus write front-end for ECC-protected memory: full writes go straight
// out, partial writes do read-modify-write, errors and timeouts end in o_err.
module edc_ecc_writer
  import edc_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sel,
  input  logic              i_we,
  input  logic [3:0]        i_byte_en,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_bus_data,
  input  logic [31:0]       i_mem_rdata,
  input  logic              i_rd_ue,
  input  logic              i_mem_ack,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [31:0]       o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [7:0]        o_mem_ecc,
  output logic              o_ack,
  output logic              o_err,
  output logic              o_busy
);

  localparam int                CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TMO   = CNT_W'(TIMEOUT);

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [7:0]         ecc_q, ecc_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  logic [31:0]        enc_data_s;
  logic [7:0]         enc_ecc_s;

  // The buffer entering WRITE is the merged word after a read, else the bus word.
  assign enc_data_s = (state_q == ST_RMW_READ) ? merge_bytes(i_mem_rdata, data_q, be_q)
                                               : i_bus_data;

  edc_secded_enc u_enc (
    .data_i (enc_data_s),
    .ecc_o  (enc_ecc_s)
  );

  // Next-state and datapath loads.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    ecc_d   = ecc_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (i_sel && i_we) begin
          addr_d = i_addr;
          data_d = i_bus_data;
          be_d   = i_byte_en;
          wait_d = '0;
          if (i_byte_en == 4'hF) begin
            state_d = ST_WRITE;
            wdata_d = enc_data_s;
            ecc_d   = enc_ecc_s;
          end else if (i_byte_en == 4'h0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RMW_READ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RMW_READ: begin
        if (i_mem_ack) begin
          if (i_rd_ue) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_WRITE;
            wdata_d = enc_data_s;
            ecc_d   = enc_ecc_s;
            wait_d  = '0;
          end
        end else if (wait_q == TMO) begin
          state_d = ST_ERROR;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      ST_WRITE: begin
        if (i_mem_ack) begin
          state_d = ST_DONE;
        end else if (wait_q == TMO) begin
          state_d = ST_ERROR;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control outputs are decoded from the next state so they register cleanly.
  always_comb begin
    req_d  = (state_d == ST_RMW_READ) || (state_d == ST_WRITE);
    we_d   = (state_d == ST_WRITE);
    ack_d  = (state_d == ST_DONE) || (state_d == ST_ERROR);
    err_d  = (state_d == ST_ERROR);
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      ecc_q   <= 8'd0;
      wait_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ecc_q   <= ecc_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign o_mem_req   = req_q;
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_ecc   = ecc_q;
  assign o_ack       = ack_q;
  assign o_err       = err_q;
  assign o_busy      = busy_q;

endmodule
